// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and constants for the register file with pending-write scoreboard.
// Holds index/value types, register roles, shift encodings and the forwarding priority pick.
package regfile_scoreboard_pkg;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned REG_W     = 32;
  localparam int unsigned NR_DEF    = 32;
  localparam int unsigned FLAGS_IDX = NR_DEF - 1;
  localparam int unsigned PC_IDX    = NR_DEF - 2;
  localparam int unsigned MAX_FWD   = 8;

  typedef logic [IDX_W-1:0] regind_t;
  typedef logic [REG_W-1:0] regval_t;

  typedef enum logic [2:0] {
    SH_NOP,
    SH_LSL,
    SH_LSR,
    SH_ASR,
    SH_ROR
  } shift_op_t;

  localparam shift_op_t NOP = SH_NOP;

  // Lowest set bit wins (channel 0 is the youngest producer); -1 when nothing matches.
  function automatic int fwd_priority(input logic [MAX_FWD-1:0] match);
    int sel;
    sel = -1;
    for (int c = MAX_FWD - 1; c >= 0; c--) begin
      if (match[c]) sel = c;
    end
    return sel;
  endfunction
endpackage

// File: rtl/regfile_scoreboard_pending_counter.sv
// Per-register outstanding-write counter: saturating up/down with a sticky underflow flag.
module pending_counter #(
  parameter int unsigned PEND_MAX = 3,
  parameter int unsigned CW       = $clog2(PEND_MAX + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          underflow
);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: if (count != CW'(PEND_MAX)) count <= count + 1'b1;
        2'b01: begin
          if (count == '0) underflow <= 1'b1;
          else             count     <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// NR x W register file with prioritised forwarding, write-through reads and a
// per-register pending-write scoreboard that raises hold on unresolved reads.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned NR       = NR_DEF,
  parameter int unsigned W        = 32,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NFWD     = 2,
  parameter int unsigned PEND_MAX = 3,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NREAD-1:0]           rd_en,
  input  regind_t [NREAD-1:0]        rd_index,
  output logic [NREAD-1:0][W-1:0]    rd_value,
  input  logic [NFWD-1:0]            fwd_valid,
  input  regind_t [NFWD-1:0]         fwd_index,
  input  logic [NFWD-1:0][W-1:0]     fwd_value,
  input  logic [NFWD-1:0]            fwd_has_upper,
  input  logic [NFWD-1:0][W-1:0]     fwd_upper_value,
  input  logic                       wr_valid,
  input  regind_t                    wr_index,
  input  logic [W-1:0]               wr_value,
  input  logic                       wr_has_upper,
  input  logic [W-1:0]               wr_upper_value,
  input  logic                       claim_valid,
  input  regind_t                    claim_index,
  input  logic                       claim_has_upper,
  output logic                       hold,
  output logic [3:0]                 flags_value,
  output logic [W-1:0]               pc_value,
  output logic                       err_underflow
);
  localparam int unsigned CW   = $clog2(PEND_MAX + 1);
  localparam int          LAST = int'(NR) - 1;
  localparam int unsigned PC_R = NR - 2;

  logic [W-1:0]         r_regs [NR];
  logic [CW-1:0]        w_count [NR];
  logic [NR-1:1]        w_claim_hit;
  logic [NR-1:1]        w_inc;
  logic [NR-1:1]        w_dec;
  logic [NR-1:1]        w_uflow;
  logic                 w_full;
  logic [NREAD-1:0]     w_stall;
  logic [MAX_FWD-1:0]   w_mvec;
  int                   w_sel;

  // True when a (valid, index, has_upper) producer targets register t; index 0 and the
  // upper half of a pair starting at the last register never match.
  function automatic logic hits(input logic v, input regind_t idx, input logic up,
                                input regind_t t);
    return v && (t != '0) &&
           ((idx == t) || (up && int'(idx) != LAST && int'(idx) + 1 == int'(t)));
  endfunction

  always_comb begin
    w_claim_hit = '0;
    w_dec       = '0;
    w_full      = 1'b0;
    for (int r = 1; r < int'(NR); r++) begin
      w_claim_hit[r] = hits(claim_valid, claim_index, claim_has_upper, regind_t'(r));
      w_dec[r]       = hits(wr_valid, wr_index, wr_has_upper, regind_t'(r));
      // A register retiring this cycle nets out with the claim, so it does not block.
      if (w_claim_hit[r] && w_count[r] == CW'(PEND_MAX) && !w_dec[r]) w_full = 1'b1;
    end
    w_inc = w_full ? '0 : w_claim_hit;
  end

  assign w_count[0] = '0;
  for (genvar r = 1; r < NR; r++) begin : g_cnt
    pending_counter #(.PEND_MAX(PEND_MAX), .CW(CW)) u_cnt (
      .clock     (clock),
      .reset_n   (reset_n),
      .inc       (w_inc[r]),
      .dec       (w_dec[r]),
      .count     (w_count[r]),
      .underflow (w_uflow[r])
    );
  end

  always_comb begin
    rd_value = '0;
    w_stall  = '0;
    w_mvec   = '0;
    w_sel    = -1;
    for (int p = 0; p < int'(NREAD); p++) begin
      w_mvec = '0;
      for (int c = 0; c < int'(NFWD); c++) begin
        w_mvec[c] = hits(fwd_valid[c], fwd_index[c], fwd_has_upper[c], rd_index[p]);
      end
      w_sel = fwd_priority(w_mvec);
      if (rd_index[p] == '0) begin
        rd_value[p] = '0;
      end else if (w_sel >= 0) begin
        for (int c = 0; c < int'(NFWD); c++) begin
          if (c == w_sel)
            rd_value[p] = (fwd_index[c] == rd_index[p]) ? fwd_value[c] : fwd_upper_value[c];
        end
      end else if (hits(wr_valid, wr_index, 1'b0, rd_index[p])) begin
        rd_value[p] = wr_value;
      end else if (hits(wr_valid, wr_index, wr_has_upper, rd_index[p])) begin
        rd_value[p] = wr_upper_value;
      end else begin
        rd_value[p] = r_regs[rd_index[p]];
      end
      w_stall[p] = rd_en[p] && (rd_index[p] != '0) && (w_count[rd_index[p]] != '0) && (w_sel < 0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < int'(NR); r++) begin
        r_regs[r] <= (r == int'(PC_R)) ? RESET_PC : '0;
      end
    end else if (wr_valid) begin
      if (wr_index != '0) r_regs[wr_index] <= wr_value;
      if (wr_has_upper && int'(wr_index) != LAST) r_regs[wr_index + 1'b1] <= wr_upper_value;
    end
  end

  assign hold          = w_full || (|w_stall);
  assign flags_value   = r_regs[NR-1][3:0];
  assign pc_value      = r_regs[PC_R];
  assign err_underflow = |w_uflow;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: driver pushes model predictions, a monitor pops and compares DUT outputs.
module tb_regfile_scoreboard;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic                 clock;
  logic                 reset_n;
  logic [1:0]           rd_en;
  logic [1:0][4:0]      rd_index;
  logic [1:0][31:0]     rd_value;
  logic [1:0]           fwd_valid;
  logic [1:0][4:0]      fwd_index;
  logic [1:0][31:0]     fwd_value;
  logic [1:0]           fwd_has_upper;
  logic [1:0][31:0]     fwd_upper_value;
  logic                 wr_valid;
  logic [4:0]           wr_index;
  logic [31:0]          wr_value;
  logic                 wr_has_upper;
  logic [31:0]          wr_upper_value;
  logic                 claim_valid;
  logic [4:0]           claim_index;
  logic                 claim_has_upper;
  logic                 hold;
  logic [3:0]           flags_value;
  logic [31:0]          pc_value;
  logic                 err_underflow;

  regfile_scoreboard #(.RESET_PC(RPC)) dut (
    .clock(clock), .reset_n(reset_n), .rd_en(rd_en), .rd_index(rd_index), .rd_value(rd_value),
    .fwd_valid(fwd_valid), .fwd_index(fwd_index), .fwd_value(fwd_value),
    .fwd_has_upper(fwd_has_upper), .fwd_upper_value(fwd_upper_value),
    .wr_valid(wr_valid), .wr_index(wr_index), .wr_value(wr_value),
    .wr_has_upper(wr_has_upper), .wr_upper_value(wr_upper_value),
    .claim_valid(claim_valid), .claim_index(claim_index), .claim_has_upper(claim_has_upper),
    .hold(hold), .flags_value(flags_value), .pc_value(pc_value), .err_underflow(err_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rv0;
    logic [31:0] rv1;
    logic        hold;
    logic [3:0]  flags;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t        q[$];
  event        ev_mon;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] m_regs [32];
  int          m_cnt [32];
  bit          m_err;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: registers as a plain array, scoreboard as integer counts.
  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_cnt[i]  = 0;
    end
    m_regs[30] = RPC;
    m_err = 1'b0;
  endfunction

  function automatic bit targets(bit v, int idx, bit up, int t);
    if (!v || t == 0) return 1'b0;
    if (idx == t) return 1'b1;
    return up && idx != 31 && idx + 1 == t;
  endfunction

  function automatic bit m_fwd_hit(int t);
    for (int c = 0; c < 2; c++)
      if (targets(fwd_valid[c], int'(fwd_index[c]), fwd_has_upper[c], t)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(int t);
    if (t == 0) return 32'h0;
    for (int c = 0; c < 2; c++) begin
      if (fwd_valid[c] && int'(fwd_index[c]) == t) return fwd_value[c];
      if (targets(fwd_valid[c], int'(fwd_index[c]), fwd_has_upper[c], t)) return fwd_upper_value[c];
    end
    if (wr_valid && int'(wr_index) == t) return wr_value;
    if (targets(wr_valid, int'(wr_index), wr_has_upper, t)) return wr_upper_value;
    return m_regs[t];
  endfunction

  function automatic bit m_full();
    for (int t = 1; t < 32; t++)
      if (targets(claim_valid, int'(claim_index), claim_has_upper, t) && m_cnt[t] == 3 &&
          !targets(wr_valid, int'(wr_index), wr_has_upper, t)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_hold();
    if (m_full()) return 1'b1;
    for (int p = 0; p < 2; p++)
      if (rd_en[p] && rd_index[p] != 0 && m_cnt[rd_index[p]] > 0 && !m_fwd_hit(int'(rd_index[p])))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_update();
    bit full;
    full = m_full();
    for (int t = 1; t < 32; t++) begin
      bit c, w;
      c = targets(claim_valid, int'(claim_index), claim_has_upper, t) && !full;
      w = targets(wr_valid, int'(wr_index), wr_has_upper, t);
      if (c && !w) m_cnt[t]++;
      else if (w && !c) begin
        if (m_cnt[t] == 0) m_err = 1'b1;
        else m_cnt[t]--;
      end
    end
    if (wr_valid) begin
      if (wr_index != 0) m_regs[wr_index] = wr_value;
      if (wr_has_upper && wr_index != 31) m_regs[int'(wr_index) + 1] = wr_upper_value;
    end
  endfunction

  task automatic idle();
    rd_en = '0; rd_index = '0;
    fwd_valid = '0; fwd_index = '0; fwd_value = '0; fwd_has_upper = '0; fwd_upper_value = '0;
    wr_valid = 0; wr_index = 0; wr_value = 0; wr_has_upper = 0; wr_upper_value = 0;
    claim_valid = 0; claim_index = 0; claim_has_upper = 0;
  endtask

  task automatic settle();
    exp_t e;
    #1;
    if (!reset_n) m_reset();
    e.rv0 = m_read(int'(rd_index[0]));
    e.rv1 = m_read(int'(rd_index[1]));
    e.hold = m_hold();
    e.flags = m_regs[31][3:0];
    e.pc = m_regs[30];
    e.err = m_err;
    q.push_back(e);
    ->ev_mon;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset_n) m_update();
    @(negedge clock);
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 99) < 85) return 5'($urandom_range(0, 9));
    return 5'($urandom_range(28, 31));
  endfunction

  initial begin : monitor
    forever begin
      exp_t e;
      @(ev_mon);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rd_value0", rd_value[0], e.rv0);
        chk("rd_value1", rd_value[1], e.rv1);
        chk("hold", 32'(hold), 32'(e.hold));
        chk("flags_value", 32'(flags_value), 32'(e.flags));
        chk("pc_value", pc_value, e.pc);
        chk("err_underflow", 32'(err_underflow), 32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : driver
    idle();
    reset_n = 1'b0;
    m_reset();
    @(negedge clock);
    rd_en = 2'b11; rd_index[0] = 5'd0; rd_index[1] = 5'd30;
    settle();
    chk("reset_r0", rd_value[0], 32'h0);
    chk("reset_pc", rd_value[1], RPC);
    chk("reset_hold", 32'(hold), 32'h0);
    tick();
    rd_index[0] = 5'd5; rd_index[1] = 5'd0;
    cyc();
    reset_n = 1'b1;
    cyc();

    // Paired write with same-cycle write-through, then array readback.
    wr_valid = 1; wr_index = 5'd5; wr_value = 32'hDEADBEEF;
    wr_has_upper = 1; wr_upper_value = 32'h12345678;
    rd_index[0] = 5'd5; rd_index[1] = 5'd6;
    settle();
    chk("wt_r5", rd_value[0], 32'hDEADBEEF);
    chk("wt_r6", rd_value[1], 32'h12345678);
    tick();
    wr_valid = 0; wr_has_upper = 0;
    settle();
    chk("arr_r5", rd_value[0], 32'hDEADBEEF);
    chk("arr_r6", rd_value[1], 32'h12345678);
    tick();

    // Claim r7, then resolve the stall through forwarding priority.
    idle();
    claim_valid = 1; claim_index = 5'd7;
    cyc();
    idle();
    rd_en = 2'b01; rd_index[0] = 5'd7;
    settle();
    chk("claim_r7_hold", 32'(hold), 32'h1);
    tick();
    fwd_valid[1] = 1; fwd_index[1] = 5'd7; fwd_value[1] = 32'h11;
    settle();
    chk("fwd1_hold", 32'(hold), 32'h0);
    chk("fwd1_val", rd_value[0], 32'h11);
    tick();
    fwd_valid[0] = 1; fwd_index[0] = 5'd7; fwd_value[0] = 32'h22;
    settle();
    chk("fwd0_prio", rd_value[0], 32'h22);
    tick();

    // Saturate r9, net claim+retire, then one retire frees a slot.
    idle();
    claim_valid = 1; claim_index = 5'd9;
    repeat (3) cyc();
    settle();
    chk("sat_hold", 32'(hold), 32'h1);
    tick();
    wr_valid = 1; wr_index = 5'd9; wr_value = 32'h99;
    settle();
    chk("net_hold", 32'(hold), 32'h0);
    tick();
    wr_valid = 0;
    settle();
    chk("still3_hold", 32'(hold), 32'h1);
    tick();
    idle();
    wr_valid = 1; wr_index = 5'd9; wr_value = 32'h98;
    cyc();
    idle();
    claim_valid = 1; claim_index = 5'd9;
    settle();
    chk("cnt2_hold", 32'(hold), 32'h0);
    tick();

    // Top register pair, r0 immunity, underflow stickiness.
    idle();
    wr_valid = 1; wr_index = 5'd31; wr_value = 32'hA5A5A5A5;
    wr_has_upper = 1; wr_upper_value = 32'h5A5A5A5A;
    rd_index[0] = 5'd31; rd_index[1] = 5'd0;
    cyc();
    wr_index = 5'd0; wr_value = 32'hFFFF; wr_has_upper = 0;
    cyc();
    idle();
    settle();
    chk("r0_zero", rd_value[1], 32'h0);
    chk("flags_r31", 32'(flags_value), 32'h5);
    tick();
    wr_valid = 1; wr_index = 5'd4; wr_value = 32'h4;
    cyc();
    idle();
    settle();
    chk("underflow_set", 32'(err_underflow), 32'h1);
    tick();
    cyc();

    // Async reset while r3 has a pending claim.
    claim_valid = 1; claim_index = 5'd3;
    cyc();
    idle();
    rd_en = 2'b01; rd_index[0] = 5'd3;
    settle();
    chk("r3_hold", 32'(hold), 32'h1);
    tick();
    #2 reset_n = 1'b0;
    settle();
    chk("rst_hold", 32'(hold), 32'h0);
    chk("rst_pc", pc_value, RPC);
    chk("rst_err", 32'(err_underflow), 32'h0);
    tick();
    reset_n = 1'b1;
    cyc();

    // Randomised traffic against the model.
    for (int n = 0; n < 800; n++) begin
      reset_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      rd_en = 2'($urandom);
      rd_index[0] = pick(); rd_index[1] = pick();
      for (int c = 0; c < 2; c++) begin
        fwd_valid[c] = ($urandom_range(0, 99) < 25);
        fwd_index[c] = pick();
        fwd_value[c] = $urandom;
        fwd_has_upper[c] = $urandom_range(0, 1);
        fwd_upper_value[c] = $urandom;
      end
      wr_valid = ($urandom_range(0, 99) < 40);
      wr_index = pick(); wr_value = $urandom;
      wr_has_upper = $urandom_range(0, 1); wr_upper_value = $urandom;
      claim_valid = ($urandom_range(0, 99) < 50);
      claim_index = pick(); claim_has_upper = $urandom_range(0, 1);
      cyc();
    end

    #1;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the fixed 4-entry register file and its single-channel feedback logic. It holds NR registers of W bits and serves NREAD combinational read ports. Each read resolves through NFWD prioritised forwarding channels and a write-through path, with paired upper-value writes on every channel. A per-register pending-write scoreboard drives the hold output used by i_flow_control, so decode/read stalls on values not yet produced.

Parameters:
NR, 32, number of registers; index 0 hard-wired to zero; Flags = NR-1, PC = NR-2
W, 32, register width in bits
NREAD, 2, number of read ports
NFWD, 2, forwarding channels; channel 0 is youngest and has highest priority
PEND_MAX, 3, maximum outstanding claims per register (counter width clog2(PEND_MAX+1))
RESET_PC, 0, reset value of the PC register

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rd_en  in  NREAD  read port request
rd_index  in  NREAD x 5  read register index
rd_value  out  NREAD x W  resolved read data (combinational)
fwd_valid  in  NFWD  forwarding channel valid
fwd_index  in  NFWD x 5  forwarded target index
fwd_value  in  NFWD x W  forwarded value
fwd_has_upper  in  NFWD  channel also carries index+1
fwd_upper_value  in  NFWD x W  value for index+1
wr_valid  in  1  retire write
wr_index  in  5  write target
wr_value  in  W  write data
wr_has_upper  in  1  paired write to wr_index+1
wr_upper_value  in  W  paired write data
claim_valid  in  1  issue claims a future write
claim_index  in  5  claimed target
claim_has_upper  in  1  claim also covers claim_index+1
hold  out  1  stall request to the upstream stage
flags_value  out  4  low 4 bits of register Flags
pc_value  out  W  register PC
err_underflow  out  1  sticky: retire with zero pending count

Behaviour:
- Reset, asynchronous on reset_n low: all registers 0 except PC = RESET_PC; all pending counts 0; err_underflow 0. hold, rd_value, flags_value and pc_value follow combinationally from the reset state.
- Reads have 0-cycle latency. Each port selects the first match in this order:
  1. Index 0 returns 0.
  2. Forwarding channels, lowest channel number first. A channel matches if valid and index==rd_index, or if has_upper and index+1==rd_index.
  3. Write port match in the same cycle (write-through).
  4. Array contents.
- Forwarding or writes targeting index 0 are never matched.
- A write takes effect at the next rising clock edge. Writes to index 0 are discarded.
- Upper-value rule: if the primary index is NR-1, the upper value is discarded on every channel; there is no wrap to index 0.
- Scoreboard, per register r:
  - claim on r increments count(r).
  - wr_valid on r decrements count(r).
  - Simultaneous claim and write on the same r leave the count unchanged.
  - claim_has_upper and wr_has_upper apply the same rule to r+1 (subject to the NR-1 rule). Index 0 is never counted.
- A decrement when count(r) is 0 leaves the count at 0 and sets err_underflow, which stays set until reset.
- hold = 1 when either condition holds:
  - (a) claim_valid is set and any claimed register is at PEND_MAX. The claim is not applied in that cycle; the upstream stage retries.
  - (b) any enabled read port's index has count > 0 with no forwarding-channel match.
- A write-through match does not clear hold; the count still reflects the claim until the edge.
- Reset asserted mid-operation clears all state immediately, and in-flight claims are lost. Deassertion is synchronised externally.

Decomposition:
- Shared package: regind_t, regval_t parameterised by W; Flags and PC index constants; Nop; the shift-operation encodings; a function returning the forwarding-match priority index.
- One sub-module, pending_counter: a saturating up/down counter with an underflow flag, instantiated NR-1 times via generate.

Test Plan:
- Reset, then read ports at 0, NR-2 and 5 -> rd_value 0, RESET_PC, 0; hold 0; err_underflow 0.
- Write 0xDEADBEEF to r5 with upper 0x12345678 to r6, then read r5 and r6 next cycle -> 0xDEADBEEF and 0x12345678. Same-cycle read returns the same values via write-through.
- Claim r7, then enable a read of r7 with no forwarding -> hold 1. Present fwd ch1 for r7 = 0x11 -> hold 0, value 0x11. Also present ch0 for r7 = 0x22 -> value 0x22.
- Claim r9 three times (PEND_MAX=3), then claim again -> hold 1 and count stays 3. Retire r9 together with a claim in the same cycle -> count stays 3; a further retire -> count 2.
- Write r31 with has_upper -> r31 updated, r0 still reads 0. Write r0 = 0xFFFF -> r0 reads 0. Retire r4 with count 0 -> err_underflow 1 until reset.
- Assert reset_n low mid-stream with r3 claimed -> count 0 and hold drops immediately; PC reads RESET_PC.
